led_owner_arbiter: RTL and testbench
====================================

Name: led_owner_arbiter

Overview:
- Decides which requester drives the 16 board LEDs. Requesters, in priority order: alarm blink, mode-change banner, minigame pattern, normal status.
- Sits between the mode FSM, alarm, minigame and the LED pins, replacing direct LED composition.
- Adds a timed banner on every mode change, a pending-banner flag while the alarm rings, and registered glitch-free LED output.

Parameters:
- BLINK_HALF, 25_000_000, MCLK cycles per alarm blink half-period (0.5 s at 50 MHz).
- BANNER_CYCLES, 100_000_000, MCLK cycles the mode banner is held (2 s).

Ports:
- MCLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge MCLK).
- CLK1  in  1  1 Hz heartbeat level, shown on LED[0] in NORMAL and GAME.
- MODE  in  4  current mode code.
- game_req  in  1  minigame requests the LEDs (level).
- game_leds  in  10  minigame pattern.
- alarm_req  in  1  alarm ringing (level).
- LED  out  16  registered LED drive.
- owner  out  2  registered current owner (NORMAL=0, BANNER=1, GAME=2, ALARM=3).

Behaviour:
- Reset (RESET=0 at a posedge):
  - LED=16'h0000, owner=NORMAL.
  - blink_cnt=0, blink_state=0, banner_cnt=0, banner_pending=0.
  - mode_q<=MODE, so no banner fires after reset release.
  - Reset overrides everything, including mid-banner and mid-alarm.
- mode_chg = (MODE != mode_q). mode_q<=MODE every non-reset cycle.
- Next-owner priority each cycle: ALARM > BANNER > GAME > NORMAL.
- NORMAL/GAME transitions:
  - alarm_req -> ALARM.
  - else mode_chg -> BANNER.
  - else game_req -> GAME.
  - else NORMAL.
- BANNER:
  - banner_cnt loads 0 on entry and counts up.
  - alarm_req preempts to ALARM and sets banner_pending (the banner restarts after the alarm).
  - mode_chg while in BANNER restarts banner_cnt at 0, including on the expiry cycle.
  - Expiry when banner_cnt==BANNER_CYCLES-1 -> GAME if game_req, else NORMAL.
  - Result: the banner occupies exactly BANNER_CYCLES cycles.
- ALARM:
  - On entry blink_state=1 and blink_cnt=0. When blink_cnt==BLINK_HALF-1, blink_state toggles and blink_cnt wraps to 0.
  - mode_chg during ALARM sets banner_pending and does not leave ALARM.
  - alarm_req=0 -> BANNER if banner_pending (then clear it), else GAME if game_req, else NORMAL. blink_cnt and blink_state clear on exit.
- Simultaneous alarm_req and mode_chg from NORMAL/GAME/BANNER: go to ALARM and set banner_pending.
- LED content is computed from next owner and current inputs, then registered. It changes on the same edge as owner, one cycle after the inputs are sampled.
  - NORMAL: {MODE, 10'b0, 1'b0, CLK1}.
  - BANNER: {MODE, MODE, MODE, MODE}.
  - GAME: {MODE, game_leds, 1'b0, CLK1}.
  - ALARM: blink_state ? 16'hFFFF : 16'h0000 (first ALARM cycle shows FFFF).
- Width rules:
  - Counters are $clog2 of their parameter, minimum 1 bit.
  - Comparisons are against parameter-1, so there is no overflow or wrap past the terminal value.
- Every output is registered; no combinational path from inputs to LED.

Decomposition:
- Package led_pkg:
  - owner encodings OWN_NORMAL/OWN_BANNER/OWN_GAME/OWN_ALARM (2-bit typedef owner_t).
  - Default timing constants BLINK_HALF_DEF, BANNER_CYCLES_DEF.
- Sub-module led_blink_timer:
  - Ports MCLK, RESET, en, state.
  - Free-running half-period counter; restarts with state=1 when en rises and clears when en=0.
  - Instantiated once for ALARM.
- The arbiter FSM, banner counter and LED mux stay in the top.

Test Plan (BLINK_HALF=4, BANNER_CYCLES=8, CLK1 held 1 unless noted):
- Reset: hold RESET=0 3 cycles with MODE=5 -> LED=0000, owner=0. Release -> next edge LED=16'h5001, owner=0, no banner.
- Banner: MODE 5->A -> next edge owner=1 with LED=AAAA for exactly 8 cycles, then LED=A001, owner=0. A second MODE change at cycle 7 -> banner extends 8 more cycles with the new nibble.
- Game: MODE=2, game_req=1, game_leds=3FF -> LED=2FFD, owner=2. Set CLK1=0 -> LED=2FFC next edge. game_req=0 -> LED=2001.
- Alarm preempts game: alarm_req=1 -> FFFF x4, 0000 x4, FFFF x4. Drop alarm_req -> next edge LED=2FFD, owner=2.
- Pending banner: during ALARM change MODE 2->7 -> LED keeps blinking. Drop alarm -> owner=1, LED=7777 for 8 cycles, then GAME 7FFD.
- Reset mid-operation: RESET=0 at banner cycle 3 or during ALARM -> LED=0000, owner=0 next edge, banner_pending cleared. After release no banner and no blink.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - owner encodings and default timing for the LED owner arbiter
package led_pkg;

  typedef enum logic [1:0] {
    OWN_NORMAL = 2'd0,
    OWN_BANNER = 2'd1,
    OWN_GAME   = 2'd2,
    OWN_ALARM  = 2'd3
  } owner_t;

  localparam int BLINK_HALF_DEF    = 25_000_000;
  localparam int BANNER_CYCLES_DEF = 100_000_000;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - alarm blink half-period timer; state is the value for the upcoming cycle
module led_blink_timer #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic en,
  output logic state
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_q;
  logic          st_q;
  logic          en_q;

  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      cnt_q <= '0;
      st_q  <= 1'b0;
      en_q  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      st_q  <= 1'b0;
      en_q  <= 1'b0;
    end else if (!en_q) begin
      cnt_q <= '0;
      st_q  <= 1'b1;
      en_q  <= 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      st_q  <= ~st_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Look-ahead so the owner/LED register sees the lit phase on the very first alarm edge.
  always_comb begin
    state = 1'b0;
    if (en) begin
      if (!en_q)                  state = 1'b1;
      else if (cnt_q == CNT_LAST) state = ~st_q;
      else                        state = st_q;
    end
  end

endmodule

// File: rtl/led_owner_arbiter.sv
// rtl/led_owner_arbiter.sv - picks which requester drives the 16 LEDs and registers the result
module led_owner_arbiter
  import led_pkg::*;
#(
  parameter int BLINK_HALF    = BLINK_HALF_DEF,
  parameter int BANNER_CYCLES = BANNER_CYCLES_DEF
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        CLK1,
  input  logic [3:0]  MODE,
  input  logic        game_req,
  input  logic [9:0]  game_leds,
  input  logic        alarm_req,
  output logic [15:0] LED,
  output logic [1:0]  owner
);

  localparam int BW = (BANNER_CYCLES > 1) ? $clog2(BANNER_CYCLES) : 1;
  localparam logic [BW-1:0] BANNER_LAST = BW'(BANNER_CYCLES - 1);

  owner_t        owner_q, owner_n;
  logic [3:0]    mode_q;
  logic [BW-1:0] banner_cnt, banner_cnt_n;
  logic          banner_pending, banner_pending_n;
  logic [15:0]   led_n;
  logic          blink_state;
  logic          mode_chg;

  assign mode_chg = (MODE != mode_q);
  assign owner    = owner_q;

  led_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .MCLK  (MCLK),
    .RESET (RESET),
    .en    (owner_n == OWN_ALARM),
    .state (blink_state)
  );

  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      owner_q        <= OWN_NORMAL;
      mode_q         <= MODE;
      banner_cnt     <= '0;
      banner_pending <= 1'b0;
      LED            <= 16'h0000;
    end else begin
      owner_q        <= owner_n;
      mode_q         <= MODE;
      banner_cnt     <= banner_cnt_n;
      banner_pending <= banner_pending_n;
      LED            <= led_n;
    end
  end

  always_comb begin
    owner_n          = owner_q;
    banner_cnt_n     = banner_cnt;
    banner_pending_n = banner_pending;
    case (owner_q)
      OWN_NORMAL, OWN_GAME: begin
        if (alarm_req) begin
          owner_n = OWN_ALARM;
          if (mode_chg) banner_pending_n = 1'b1;
        end else if (mode_chg) begin
          owner_n      = OWN_BANNER;
          banner_cnt_n = '0;
        end else begin
          owner_n = game_req ? OWN_GAME : OWN_NORMAL;
        end
      end
      OWN_BANNER: begin
        if (alarm_req) begin
          owner_n          = OWN_ALARM;
          banner_pending_n = 1'b1;
        end else if (mode_chg) begin
          banner_cnt_n = '0;
        end else if (banner_cnt == BANNER_LAST) begin
          owner_n = game_req ? OWN_GAME : OWN_NORMAL;
        end else begin
          banner_cnt_n = banner_cnt + BW'(1);
        end
      end
      OWN_ALARM: begin
        // A mode change on the same cycle the alarm drops still earns its banner.
        if (!alarm_req) begin
          if (banner_pending || mode_chg) begin
            owner_n          = OWN_BANNER;
            banner_cnt_n     = '0;
            banner_pending_n = 1'b0;
          end else begin
            owner_n = game_req ? OWN_GAME : OWN_NORMAL;
          end
        end else if (mode_chg) begin
          banner_pending_n = 1'b1;
        end
      end
      default: owner_n = OWN_NORMAL;
    endcase
  end

  always_comb begin
    led_n = {MODE, 10'b0, 1'b0, CLK1};
    case (owner_n)
      OWN_BANNER: led_n = {MODE, MODE, MODE, MODE};
      OWN_GAME:   led_n = {MODE, game_leds, 1'b0, CLK1};
      OWN_ALARM:  led_n = blink_state ? 16'hFFFF : 16'h0000;
      default:    led_n = {MODE, 10'b0, 1'b0, CLK1};
    endcase
  end

endmodule

// File: tb/tb_led_owner_arbiter.sv
// tb/tb_led_owner_arbiter.sv - directed vector bench for led_owner_arbiter
module tb_led_owner_arbiter;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        CLK1;
  logic [3:0]  MODE;
  logic        game_req;
  logic [9:0]  game_leds;
  logic        alarm_req;
  logic [15:0] LED;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  mode;
    logic        clk1;
    logic        greq;
    logic [9:0]  gleds;
    logic        areq;
    int          reps;
    logic [15:0] exp_led;
    logic [1:0]  exp_own;
  } vec_t;

  vec_t vecs[$];

  always #5 MCLK = ~MCLK;

  led_owner_arbiter #(.BLINK_HALF(4), .BANNER_CYCLES(8)) dut (
    .MCLK      (MCLK),
    .RESET     (RESET),
    .CLK1      (CLK1),
    .MODE      (MODE),
    .game_req  (game_req),
    .game_leds (game_leds),
    .alarm_req (alarm_req),
    .LED       (LED),
    .owner     (owner)
  );

  task automatic add(input logic rst, input logic [3:0] mode, input logic clk1,
                     input logic greq, input logic [9:0] gleds, input logic areq,
                     input int reps, input logic [15:0] el, input logic [1:0] eo);
    vec_t v;
    v.rst = rst; v.mode = mode; v.clk1 = clk1; v.greq = greq; v.gleds = gleds;
    v.areq = areq; v.reps = reps; v.exp_led = el; v.exp_own = eo;
    vecs.push_back(v);
  endtask

  task automatic step_chk(input string nm, input logic [15:0] el, input logic [1:0] eo);
    @(posedge MCLK);
    #1;
    checks++;
    if (LED !== el) begin
      errors++;
      $display("FAIL %s LED got %h expected %h", nm, LED, el);
    end
    checks++;
    if (owner !== eo) begin
      errors++;
      $display("FAIL %s owner got %0d expected %0d", nm, owner, eo);
    end
  endtask

  initial begin
    RESET = 1'b0; MODE = 4'h5; CLK1 = 1'b1;
    game_req = 1'b0; game_leds = 10'h000; alarm_req = 1'b0;

    //   rst mode clk1 greq gleds  areq reps LED      owner
    add(0, 4'h5, 1, 0, 10'h000, 0, 3, 16'h0000, 2'd0);
    add(1, 4'h5, 1, 0, 10'h000, 0, 2, 16'h5001, 2'd0);
    add(1, 4'hA, 1, 0, 10'h000, 0, 8, 16'hAAAA, 2'd1);
    add(1, 4'hA, 1, 0, 10'h000, 0, 1, 16'hA001, 2'd0);
    add(1, 4'h3, 1, 0, 10'h000, 0, 8, 16'h3333, 2'd1);
    add(1, 4'hC, 1, 0, 10'h000, 0, 8, 16'hCCCC, 2'd1);
    add(1, 4'hC, 1, 0, 10'h000, 0, 1, 16'hC001, 2'd0);
    add(1, 4'h2, 1, 1, 10'h3FF, 0, 8, 16'h2222, 2'd1);
    add(1, 4'h2, 1, 1, 10'h3FF, 0, 1, 16'h2FFD, 2'd2);
    add(1, 4'h2, 0, 1, 10'h3FF, 0, 1, 16'h2FFC, 2'd2);
    add(1, 4'h2, 1, 1, 10'h3FF, 0, 1, 16'h2FFD, 2'd2);
    add(1, 4'h2, 1, 0, 10'h3FF, 0, 1, 16'h2001, 2'd0);
    add(1, 4'h2, 1, 1, 10'h155, 0, 1, 16'h2555, 2'd2);
    add(1, 4'h2, 1, 1, 10'h3FF, 0, 1, 16'h2FFD, 2'd2);
    add(1, 4'h2, 1, 1, 10'h3FF, 1, 4, 16'hFFFF, 2'd3);
    add(1, 4'h2, 1, 1, 10'h3FF, 1, 4, 16'h0000, 2'd3);
    add(1, 4'h2, 1, 1, 10'h3FF, 1, 4, 16'hFFFF, 2'd3);
    add(1, 4'h2, 1, 1, 10'h3FF, 0, 1, 16'h2FFD, 2'd2);
    add(1, 4'h2, 1, 1, 10'h3FF, 1, 2, 16'hFFFF, 2'd3);
    add(1, 4'h7, 1, 1, 10'h3FF, 1, 2, 16'hFFFF, 2'd3);
    add(1, 4'h7, 1, 1, 10'h3FF, 1, 2, 16'h0000, 2'd3);
    add(1, 4'h7, 1, 1, 10'h3FF, 0, 8, 16'h7777, 2'd1);
    add(1, 4'h7, 1, 1, 10'h3FF, 0, 1, 16'h7FFD, 2'd2);
    add(1, 4'h9, 1, 1, 10'h3FF, 1, 1, 16'hFFFF, 2'd3);
    add(1, 4'h9, 1, 1, 10'h3FF, 0, 8, 16'h9999, 2'd1);
    add(1, 4'h9, 1, 1, 10'h3FF, 0, 1, 16'h9FFD, 2'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      RESET = vecs[i].rst; MODE = vecs[i].mode; CLK1 = vecs[i].clk1;
      game_req = vecs[i].greq; game_leds = vecs[i].gleds; alarm_req = vecs[i].areq;
      for (int r = 0; r < vecs[i].reps; r++)
        step_chk($sformatf("row%0d.%0d", i, r), vecs[i].exp_led, vecs[i].exp_own);
    end

    // Reset in the middle of a banner: no banner and no blink after release.
    MODE = 4'h4;
    for (int r = 0; r < 4; r++) step_chk($sformatf("midban%0d", r), 16'h4444, 2'd1);
    RESET = 1'b0;
    step_chk("midban_rst0", 16'h0000, 2'd0);
    step_chk("midban_rst1", 16'h0000, 2'd0);
    RESET = 1'b1;
    step_chk("midban_rel0", 16'h4FFD, 2'd2);
    step_chk("midban_rel1", 16'h4FFD, 2'd2);

    // Reset during an alarm with a banner pending: the pending flag must not survive.
    alarm_req = 1'b1;
    step_chk("midalm0", 16'hFFFF, 2'd3);
    MODE = 4'h6;
    step_chk("midalm1", 16'hFFFF, 2'd3);
    RESET = 1'b0; alarm_req = 1'b0;
    step_chk("midalm_rst", 16'h0000, 2'd0);
    RESET = 1'b1;
    for (int r = 0; r < 3; r++) step_chk($sformatf("midalm_rel%0d", r), 16'h6FFD, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
